// File: rtl/mux_scan_n.sv
// mux_scan_n: registered N:1 channel mux with manual select and auto-scan.
// Auto-scan steps through unmasked channels, holding each for DWELL cycles.
//
// Ports:
//   clk, rst_n   rising-edge clock, async active-low reset
//   in_bus       CHANNELS x WIDTH packed channel data (channel k at k*WIDTH)
//   enable       1 = advance and update outputs, 0 = freeze
//   mode         0 = manual (sel_in), 1 = auto-scan (chan_mask)
//   sel_in       manual channel index
//   chan_mask    1 = channel included in auto-scan
//   out_data     registered data of the presented channel
//   out_sel      index of the presented channel
//   out_valid    out_data/out_sel meaningful this cycle
//   scan_wrap    pulse when the scan returns to the lowest unmasked channel
//   out_parity   XOR of out_data (only with MUX_SCAN_PARITY_EN defined)
//
// Optional feature macro: MUX_SCAN_PARITY_EN
module mux_scan_n #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 16,
    parameter int SEL_W    = $clog2(CHANNELS),
    parameter int DWELL    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_bus,
    input  logic                      enable,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic [CHANNELS-1:0]       chan_mask,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_valid,
    output logic                      scan_wrap
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic                      out_parity
`endif
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

    state_t            st_q, st_d;
    logic [SEL_W-1:0]  idx_q, idx_d;
    logic [DW-1:0]     dw_q, dw_d;
    // set while the mask is empty: next non-empty mask restarts at lowest
    logic              rs_q, rs_d;
    logic [WIDTH-1:0]  data_d;
    logic [SEL_W-1:0]  sel_d;
    logic              valid_d;
    logic              wrap_d;
    logic [SEL_W-1:0]  lowest;
    logic [SEL_W-1:0]  higher;
    logic              has_higher;
    logic [WIDTH-1:0]  chans [CHANNELS];

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        assign chans[k] = in_bus[k*WIDTH +: WIDTH];
    end

    // lowest unmasked channel, and nearest unmasked channel above idx_q
    always_comb begin
        lowest     = '0;
        higher     = '0;
        has_higher = 1'b0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (chan_mask[k]) begin
                lowest = SEL_W'(k);
                if (k > int'(idx_q)) begin
                    higher     = SEL_W'(k);
                    has_higher = 1'b1;
                end
            end
        end
    end

    always_comb begin
        st_d    = st_q;
        idx_d   = idx_q;
        dw_d    = dw_q;
        rs_d    = rs_q;
        data_d  = out_data;
        sel_d   = out_sel;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        if (enable) begin
            if (!mode) begin
                st_d  = MANUAL;
                dw_d  = '0;
                rs_d  = 1'b0;
                sel_d = sel_in;
                if (int'(sel_in) < CHANNELS) begin
                    data_d  = chans[sel_in];
                    valid_d = 1'b1;
                end else begin
                    data_d = '0;
                end
            end else begin
                st_d = SCAN;
                if (chan_mask == '0) begin
                    dw_d = '0;
                    rs_d = 1'b1;
                end else if (st_q != SCAN || rs_q) begin
                    idx_d   = lowest;
                    dw_d    = '0;
                    rs_d    = 1'b0;
                    valid_d = 1'b1;
                end else if (!chan_mask[idx_q] ||
                             dw_q == DW'(DWELL - 1)) begin
                    // no higher channel means we wrap (also the
                    // single-channel case, where lowest == idx_q)
                    idx_d   = has_higher ? higher : lowest;
                    wrap_d  = !has_higher;
                    dw_d    = '0;
                    valid_d = 1'b1;
                end else begin
                    dw_d    = dw_q + 1'b1;
                    valid_d = 1'b1;
                end
                if (valid_d) begin
                    sel_d  = idx_d;
                    data_d = chans[idx_d];
                end
            end
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    logic par_d;

    always_comb begin
        par_d = out_parity;
        if (valid_d) begin
            par_d = ^data_d;
        end else if (enable && !mode) begin
            par_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_parity <= 1'b0;
        end else begin
            out_parity <= par_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= IDLE;
            idx_q     <= '0;
            dw_q      <= '0;
            rs_q      <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            scan_wrap <= 1'b0;
        end else begin
            st_q      <= st_d;
            idx_q     <= idx_d;
            dw_q      <= dw_d;
            rs_q      <= rs_d;
            out_data  <= data_d;
            out_sel   <= sel_d;
            out_valid <= valid_d;
            scan_wrap <= wrap_d;
        end
    end

endmodule
